// File: rtl/weight_mem_loader_pkg.sv
// Shared network dimensions and the loader's FSM state encoding.
package weight_mem_loader_pkg;

    // Network dimensions shared with the rest of the accelerator.
    localparam int NET_KERNEL_SIZE  = 5;
    localparam int NET_KERNEL_WIDTH = 2;
    localparam int NET_TN           = 4;
    localparam int NET_TM           = 4;

    // Loader FSM states.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/weight_mem_loader.sv
// Streams kernel words from a valid/ready source into the weight RAM write
// port, one kernel per RAM word, starting at a latched base address.
//
// Handshake: a beat transfers on a rising edge where s_valid && s_ready.
// s_valid may rise or fall at any time. s_ready is registered, is high
// only in LOAD while words remain, and drops the cycle after the final
// beat or an abort. Every transferred beat that is not cancelled by abort
// becomes exactly one RAM write in the following cycle.
import weight_mem_loader_pkg::*;

module weight_mem_loader #(
    parameter int KERNEL_SIZE  = NET_KERNEL_SIZE,
    parameter int KERNEL_WIDTH = NET_KERNEL_WIDTH,
    parameter int ADDR_W       = 10,
    localparam int WORD_W      = KERNEL_SIZE * KERNEL_SIZE * KERNEL_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [WORD_W-1:0] ram_dina,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written,
    output logic [1:0]        dbg_state
);

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;

    logic start_now;
    logic abort_now;
    logic write_now;
    logic last_beat;

    assign dbg_state = state;

    // Qualify requests by state and pick the next FSM state.
    always_comb begin
        start_now  = start && (state == IDLE);
        abort_now  = abort && (state == LOAD);
        // Abort wins over a beat transferred in the same cycle.
        write_now  = s_valid && s_ready && !abort_now;
        last_beat  = write_now && (remaining == (ADDR_W+1)'(1));
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (num_words != '0) ? LOAD : DONE;
            LOAD:    if (abort_now || last_beat) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM state plus the registered status and flow-control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == LOAD);
            // done coincides with the final write because both are set
            // by the same edge that accepts the last beat.
            done  <= (next_state == DONE);
            if (start_now) begin
                s_ready <= (num_words != '0);
            end else if (abort_now || last_beat) begin
                s_ready <= 1'b0;
            end
        end
    end

    // RAM write port: one write per surviving beat, address/data hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_ena   <= 1'b0;
            ram_wea   <= 1'b0;
            ram_addra <= '0;
            ram_dina  <= '0;
        end else begin
            ram_ena <= write_now;
            ram_wea <= write_now;
            if (write_now) begin
                ram_addra <= addr;
                ram_dina  <= s_data;
            end
        end
    end

    // Address, remaining-word and written-word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr          <= '0;
            remaining     <= '0;
            words_written <= '0;
        end else if (start_now) begin
            addr          <= base_addr;
            remaining     <= num_words;
            words_written <= '0;
        end else if (abort_now) begin
            remaining <= '0;
        end else if (write_now) begin
            // Natural overflow wraps the address from the top back to 0.
            addr          <= addr + 1'b1;
            remaining     <= remaining - 1'b1;
            words_written <= words_written + 1'b1;
        end
    end

endmodule

// File: tb/tb_weight_mem_loader.sv
// Randomised self-checking bench for weight_mem_loader with a
// transaction-level reference model.
module tb_weight_mem_loader;

    localparam int ADDR_W = 10;
    localparam int WORD_W = 50;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   num_words = '0;
    logic              s_valid = 1'b0;
    logic [WORD_W-1:0] s_data = '0;
    logic              s_ready;
    logic              ram_ena;
    logic              ram_wea;
    logic [ADDR_W-1:0] ram_addra;
    logic [WORD_W-1:0] ram_dina;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_written;
    logic [1:0]        dbg_state;

    weight_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .num_words(num_words),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
        .ram_dina(ram_dina), .busy(busy), .done(done),
        .words_written(words_written), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a load is a list of words written to base+k mod 2^ADDR_W.
    bit                m_loading = 0;
    bit                m_in_done = 0;
    int                m_left = 0;
    int                m_k = 0;
    int                m_written = 0;
    logic [ADDR_W-1:0] m_base = '0;
    logic [ADDR_W-1:0] m_last_addr = '0;
    logic [WORD_W-1:0] m_last_data = '0;
    logic [WORD_W-1:0] exp_q[$];

    task automatic model_clear();
        m_loading = 0; m_in_done = 0; m_left = 0; m_k = 0; m_written = 0;
        m_last_addr = '0; m_last_data = '0;
        exp_q.delete();
    endtask

    // One clock: predict from current inputs, advance, compare outputs.
    task automatic cycle();
        bit ready;
        bit acc;
        bit wr;
        ready = m_loading && (m_left > 0);
        check("s_ready", s_ready, ready);
        acc = ready && s_valid;
        wr = 0;
        if (!m_loading && !m_in_done) begin
            if (start) begin
                m_base = base_addr;
                m_left = int'(num_words);
                m_k = 0;
                m_written = 0;
                if (m_left > 0) m_loading = 1;
                else            m_in_done = 1;
            end
        end else if (m_in_done) begin
            m_in_done = 0;
        end else begin
            if (abort) begin
                m_loading = 0;
                m_in_done = 1;
                m_left = 0;
            end else if (acc) begin
                wr = 1;
                m_last_addr = ADDR_W'((int'(m_base) + m_k) % (1 << ADDR_W));
                m_last_data = s_data;
                exp_q.push_back(s_data);
                m_k++;
                m_written++;
                m_left--;
                if (m_left == 0) begin
                    m_loading = 0;
                    m_in_done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("ram_wea", ram_wea, wr);
        check("ram_ena", ram_ena, wr);
        check("ram_addra", ram_addra, m_last_addr);
        check("ram_dina", ram_dina, m_last_data);
        check("done", done, m_in_done);
        check("busy", busy, m_loading);
        check("words_written", words_written, m_written);
        if (wr && exp_q.size() > 0) check("data_order", ram_dina, exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        start = 0; abort = 0; s_valid = 0;
        #1;
        model_clear();
        check("rst_s_ready", s_ready, 0);
        check("rst_ram_ena", ram_ena, 0);
        check("rst_ram_wea", ram_wea, 0);
        check("rst_ram_addra", ram_addra, 0);
        check("rst_ram_dina", ram_dina, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_words_written", words_written, 0);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_done", done, 0);
            check("rst_hold_wea", ram_wea, 0);
        end
        rst_n = 1'b1;
    endtask

    function automatic logic [WORD_W-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[WORD_W-1:0];
    endfunction

    task automatic idle(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            start = 0;
            abort = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
            s_valid = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
            s_data = rand_word();
            cycle();
        end
        abort = 0; s_valid = 0;
    endtask

    // mode 0: valid held high, 1: valid 1,0,0 repeating, 2: random with noise.
    // abort_after / reset_after < 0 disables that event.
    task automatic run_load(input int base, input int num, input int mode,
                            input int abort_after, input int reset_after);
        int budget;
        int idx;
        start = 1;
        base_addr = ADDR_W'(base);
        num_words = (ADDR_W+1)'(num);
        abort = 0;
        s_valid = 0;
        cycle();
        start = 0;
        budget = 400;
        idx = 0;
        while ((m_loading || m_in_done) && budget > 0) begin
            if (reset_after >= 0 && m_written == reset_after && m_loading) begin
                apply_reset(2);
                return;
            end
            case (mode)
                0:       s_valid = 1;
                1:       s_valid = (idx % 3 == 0);
                default: s_valid = ($urandom_range(0, 2) != 0);
            endcase
            s_data = rand_word();
            abort = (abort_after >= 0 && m_k == abort_after && m_loading);
            if (mode == 2) begin
                abort = ($urandom_range(0, 40) == 0);
                start = ($urandom_range(0, 5) == 0);
                base_addr = ADDR_W'($urandom());
                num_words = (ADDR_W+1)'($urandom_range(0, 20));
            end
            cycle();
            idx++;
            budget--;
        end
        start = 0; abort = 0; s_valid = 0;
        if (budget == 0) check("load_timeout", 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        apply_reset(3);
        idle(2, 0);

        // Eight words from 0x010 with continuous valid.
        run_load(12'h010, 8, 0, -1, -1);
        check("ww_after_8", words_written, 8);
        check("last_addr_8", ram_addra, 10'h017);
        idle(2, 0);

        // Address wrap across the top of the RAM.
        run_load(12'h3FE, 4, 0, -1, -1);
        check("wrap_last_addr", ram_addra, 10'h001);
        check("ww_after_wrap", words_written, 4);
        idle(1, 0);

        // Zero-length load: immediate done, no write, never busy.
        run_load(12'h123, 0, 0, -1, -1);
        check("ww_after_zero", words_written, 0);
        idle(2, 0);

        // Stalls between beats.
        run_load(12'h050, 6, 1, -1, -1);
        check("ww_after_stall", words_written, 6);
        check("stall_last_addr", ram_addra, 10'h055);
        idle(2, 1);

        // Abort after three beats with valid high in the abort cycle.
        run_load(12'h200, 10, 0, 3, -1);
        check("ww_after_abort", words_written, 3);
        s_valid = 1;
        idle(3, 0);

        // Reset mid-load, then a clean load.
        run_load(12'h080, 5, 0, -1, 2);
        check("ww_after_reset", words_written, 0);
        idle(2, 0);
        run_load(12'h090, 5, 0, -1, -1);
        check("ww_reload", words_written, 5);
        idle(2, 0);

        // Randomised loads with stalls, stray starts and aborts.
        for (int t = 0; t < 40; t++) begin
            run_load(int'($urandom_range(0, 1023)), int'($urandom_range(0, 12)), 2, -1, -1);
            idle(int'($urandom_range(0, 3)), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
